// File: rtl/rs_station_pkg.sv
// Shared widths, entry layout and CDB wakeup helper for the reservation station.
package rs_station_pkg;

  localparam int RS_STATION_SIZE  = 16;
  localparam int RS_STATION_IDX_W = $clog2(RS_STATION_SIZE);

  localparam int REG_W    = 32;
  localparam int ROB_ID_W = 5;
  localparam int OP_W     = 6;
  localparam int IMM_W    = 32;

  typedef logic [REG_W-1:0]    reg_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [OP_W-1:0]     op_t;
  typedef logic [IMM_W-1:0]    imm_t;

  localparam op_t OP_ADD = 6'd1;
  localparam op_t OP_SUB = 6'd2;

  typedef struct packed {
    logic    busy;
    op_t     op;
    rob_id_t qj;
    rob_id_t qk;
    reg_t    vj;
    reg_t    vk;
    imm_t    imm;
    reg_t    pc;
    rob_id_t dest;
  } rs_entry_t;

  typedef struct packed {
    rob_id_t q;
    reg_t    v;
  } operand_t;

  // ALU bus wins over the LS bus when both carry the awaited producer id.
  function automatic operand_t wakeup_operand(input rob_id_t q, input reg_t v,
                                              input rob_id_t alu_dest, input reg_t alu_val,
                                              input rob_id_t ls_dest, input reg_t ls_val);
    operand_t res;
    res.q = q;
    res.v = v;
    if (q != '0 && q == alu_dest) begin
      res.q = '0;
      res.v = alu_val;
    end else if (q != '0 && q == ls_dest) begin
      res.q = '0;
      res.v = ls_val;
    end else begin
      res.q = q;
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_station_picker.sv
// Lowest-index priority encoder: reports whether any request is set and the index of the lowest one.
module rs_station_picker #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/rs_station.sv
// Reservation station for ALU/branch ops: insert, CDB wakeup, one dispatch per cycle.
// Optional statistics counters are enabled with the RS_STATION_STATS_EN macro.
module rs_station
  import rs_station_pkg::*;
#(
  parameter int RS_SIZE = RS_STATION_SIZE
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    reset_from_rob_bus,
  input  rob_id_t dest_from_issuer,
  input  op_t     op_from_issuer,
  input  rob_id_t qj_from_issuer,
  input  rob_id_t qk_from_issuer,
  input  reg_t    vj_from_issuer,
  input  reg_t    vk_from_issuer,
  input  imm_t    imm_from_issuer,
  input  reg_t    pc_from_issuer,
  output logic    is_full_to_issuer,
  input  rob_id_t dest_from_alu_bus,
  input  reg_t    value_from_alu_bus,
  input  rob_id_t dest_from_ls_bus,
  input  reg_t    value_from_ls_bus,
  output rob_id_t dest_to_alu,
  output op_t     op_to_alu,
  output reg_t    vj_to_alu,
  output reg_t    vk_to_alu,
  output imm_t    imm_to_alu,
  output reg_t    pc_to_alu
`ifdef RS_STATION_STATS_EN
  ,
  output logic [31:0] stat_insert_cnt,
  output logic [31:0] stat_dispatch_cnt,
  output logic [31:0] stat_full_cycles
`endif
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t ent [RS_SIZE];

  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [CNT_W-1:0]   free_cnt;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               ready_found;
  logic [IDX_W-1:0]   ready_idx;
  logic               ins_valid;
  rs_entry_t          new_ent;
  operand_t           wj [RS_SIZE];
  operand_t           wk [RS_SIZE];
  operand_t           nj;
  operand_t           nk;

  // Occupancy, readiness and CDB-resolved operands, all from registered state.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = ~ent[i].busy;
      ready_vec[i] = ent[i].busy && (ent[i].qj == '0) && (ent[i].qk == '0);
      free_cnt     = free_cnt + CNT_W'(free_vec[i]);
      wj[i] = wakeup_operand(ent[i].qj, ent[i].vj, dest_from_alu_bus, value_from_alu_bus,
                             dest_from_ls_bus, value_from_ls_bus);
      wk[i] = wakeup_operand(ent[i].qk, ent[i].vk, dest_from_alu_bus, value_from_alu_bus,
                             dest_from_ls_bus, value_from_ls_bus);
    end
  end

  // One slot of margin absorbs the bundle the issuer already has in flight.
  assign is_full_to_issuer = (free_cnt <= CNT_W'(1));

  rs_station_picker #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_pick (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_station_picker #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_pick (
    .req   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  // Incoming bundle with the same-cycle CDB bypass applied.
  always_comb begin
    nj = wakeup_operand(qj_from_issuer, vj_from_issuer, dest_from_alu_bus, value_from_alu_bus,
                        dest_from_ls_bus, value_from_ls_bus);
    nk = wakeup_operand(qk_from_issuer, vk_from_issuer, dest_from_alu_bus, value_from_alu_bus,
                        dest_from_ls_bus, value_from_ls_bus);
    new_ent.busy = 1'b1;
    new_ent.op   = op_from_issuer;
    new_ent.qj   = nj.q;
    new_ent.vj   = nj.v;
    new_ent.qk   = nk.q;
    new_ent.vk   = nk.v;
    new_ent.imm  = imm_from_issuer;
    new_ent.pc   = pc_from_issuer;
    new_ent.dest = dest_from_issuer;
    ins_valid    = (dest_from_issuer != '0) && free_found;
  end

  // Entry storage and registered dispatch port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent[i] <= '0;
      end
      dest_to_alu <= '0;
      op_to_alu   <= '0;
      vj_to_alu   <= '0;
      vk_to_alu   <= '0;
      imm_to_alu  <= '0;
      pc_to_alu   <= '0;
    end else if (reset_from_rob_bus) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent[i].busy <= 1'b0;
      end
      dest_to_alu <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent[i].busy) begin
          ent[i].qj <= wj[i].q;
          ent[i].vj <= wj[i].v;
          ent[i].qk <= wk[i].q;
          ent[i].vk <= wk[i].v;
        end
      end
      // Ready selection uses pre-wakeup state, so a freshly woken entry waits one edge.
      if (ready_found) begin
        dest_to_alu           <= ent[ready_idx].dest;
        op_to_alu             <= ent[ready_idx].op;
        vj_to_alu             <= ent[ready_idx].vj;
        vk_to_alu             <= ent[ready_idx].vk;
        imm_to_alu            <= ent[ready_idx].imm;
        pc_to_alu             <= ent[ready_idx].pc;
        ent[ready_idx].busy   <= 1'b0;
      end else begin
        dest_to_alu <= '0;
      end
      if (ins_valid) begin
        ent[free_idx] <= new_ent;
      end
    end
  end

`ifdef RS_STATION_STATS_EN
  // Activity counters; they wrap and are cleared together with the station contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_insert_cnt   <= 32'd0;
      stat_dispatch_cnt <= 32'd0;
      stat_full_cycles  <= 32'd0;
    end else if (reset_from_rob_bus) begin
      stat_insert_cnt   <= 32'd0;
      stat_dispatch_cnt <= 32'd0;
      stat_full_cycles  <= 32'd0;
    end else if (rdy) begin
      stat_insert_cnt   <= stat_insert_cnt + {31'd0, ins_valid};
      stat_dispatch_cnt <= stat_dispatch_cnt + {31'd0, ready_found};
      stat_full_cycles  <= stat_full_cycles + {31'd0, is_full_to_issuer};
    end else begin
      stat_insert_cnt   <= stat_insert_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_rs_station.sv
// Randomized self-checking bench for rs_station with a slot-array reference model.
module tb_rs_station;
  import rs_station_pkg::*;

  localparam int N = 16;

  logic    clk, rst, rdy, flush;
  rob_id_t dest_in, qj_in, qk_in, alu_d, ls_d;
  op_t     op_in;
  reg_t    vj_in, vk_in, pc_in, alu_v, ls_v;
  imm_t    imm_in;
  logic    full;
  rob_id_t dest_o;
  op_t     op_o;
  reg_t    vj_o, vk_o, pc_o;
  imm_t    imm_o;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // reference model: slot array plus expected ALU port
  bit      m_busy [N];
  op_t     m_op   [N];
  rob_id_t m_qj   [N], m_qk [N], m_dest [N];
  reg_t    m_vj   [N], m_vk [N], m_pc [N];
  imm_t    m_imm  [N];
  rob_id_t e_dest;
  op_t     e_op;
  reg_t    e_vj, e_vk, e_pc;
  imm_t    e_imm;

  rs_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(flush),
    .dest_from_issuer(dest_in), .op_from_issuer(op_in),
    .qj_from_issuer(qj_in), .qk_from_issuer(qk_in),
    .vj_from_issuer(vj_in), .vk_from_issuer(vk_in),
    .imm_from_issuer(imm_in), .pc_from_issuer(pc_in),
    .is_full_to_issuer(full),
    .dest_from_alu_bus(alu_d), .value_from_alu_bus(alu_v),
    .dest_from_ls_bus(ls_d), .value_from_ls_bus(ls_v),
    .dest_to_alu(dest_o), .op_to_alu(op_o), .vj_to_alu(vj_o), .vk_to_alu(vk_o),
    .imm_to_alu(imm_o), .pc_to_alu(pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_free();
    int c = 0;
    for (int i = 0; i < N; i++) if (!m_busy[i]) c++;
    return c;
  endfunction

  function automatic bit woken(input rob_id_t q);
    return (q != 5'd0) && (q == alu_d || q == ls_d);
  endfunction

  function automatic reg_t wake_val(input rob_id_t q, input reg_t v);
    if (q != 5'd0 && q == alu_d) return alu_v;
    if (q != 5'd0 && q == ls_d) return ls_v;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_op[i] = '0; m_qj[i] = '0; m_qk[i] = '0; m_dest[i] = '0;
      m_vj[i] = '0; m_vk[i] = '0; m_pc[i] = '0; m_imm[i] = '0;
    end
    e_dest = '0; e_op = '0; e_vj = '0; e_vk = '0; e_pc = '0; e_imm = '0;
  endtask

  // What one clock edge must do, given the inputs currently driven.
  task automatic model_step();
    int fidx = -1;
    int ridx = -1;
    if (flush) begin
      for (int i = 0; i < N; i++) m_busy[i] = 0;
      e_dest = '0;
    end else if (rdy) begin
      for (int i = 0; i < N; i++) begin
        if (!m_busy[i] && fidx < 0) fidx = i;
        if (m_busy[i] && m_qj[i] == 5'd0 && m_qk[i] == 5'd0 && ridx < 0) ridx = i;
      end
      if (ridx >= 0) begin
        e_dest = m_dest[ridx]; e_op = m_op[ridx]; e_vj = m_vj[ridx];
        e_vk = m_vk[ridx]; e_imm = m_imm[ridx]; e_pc = m_pc[ridx];
        m_busy[ridx] = 0;
      end else begin
        e_dest = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (m_busy[i]) begin
          m_vj[i] = wake_val(m_qj[i], m_vj[i]);
          if (woken(m_qj[i])) m_qj[i] = '0;
          m_vk[i] = wake_val(m_qk[i], m_vk[i]);
          if (woken(m_qk[i])) m_qk[i] = '0;
        end
      end
      if (dest_in != 5'd0) begin
        if (fidx < 0) begin
          n_checks++; n_errors++;
          $display("FAIL insert_on_full actual=0 free slots expected>=1");
        end else begin
          m_busy[fidx] = 1; m_op[fidx] = op_in; m_dest[fidx] = dest_in;
          m_imm[fidx] = imm_in; m_pc[fidx] = pc_in;
          m_vj[fidx] = wake_val(qj_in, vj_in); m_qj[fidx] = woken(qj_in) ? 5'd0 : qj_in;
          m_vk[fidx] = wake_val(qk_in, vk_in); m_qk[fidx] = woken(qk_in) ? 5'd0 : qk_in;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic set_idle();
    dest_in = '0; alu_d = '0; ls_d = '0; flush = 1'b0; rdy = 1'b1;
  endtask

  task automatic issue(input rob_id_t d, input op_t op, input rob_id_t qj, input rob_id_t qk,
                       input reg_t vj, input reg_t vk);
    dest_in = d; op_in = op; qj_in = qj; qk_in = qk; vj_in = vj; vk_in = vk;
    imm_in = 32'h1000 + 32'(d); pc_in = 32'h4000 + 32'(d);
  endtask

  // Continuous comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("m_dest", dest_o, e_dest);
      chk("m_op", op_o, e_op);
      chk("m_vj", vj_o, e_vj);
      chk("m_vk", vk_o, e_vk);
      chk("m_imm", imm_o, e_imm);
      chk("m_pc", pc_o, e_pc);
      chk("m_full", full, (model_free() <= 1) ? 64'd1 : 64'd0);
    end
  end

  initial begin
    rst = 1'b1;
    op_in = '0; qj_in = '0; qk_in = '0; vj_in = '0; vk_in = '0; imm_in = '0; pc_in = '0;
    alu_v = '0; ls_v = '0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dest", dest_o, 64'd0);
    chk("rst_vj", vj_o, 64'd0);
    chk("rst_pc", pc_o, 64'd0);
    chk("rst_full", full, 64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // ready insert
    issue(5'd3, OP_ADD, 5'd0, 5'd0, 32'd5, 32'd7); tick();
    set_idle(); tick();
    chk("t1_dest", dest_o, 64'd3); chk("t1_vj", vj_o, 64'd5); chk("t1_vk", vk_o, 64'd7);
    chk("t1_op", op_o, 64'(OP_ADD));
    tick();
    chk("t1_pulse", dest_o, 64'd0);

    // wakeup from ALU bus
    issue(5'd4, OP_SUB, 5'd2, 5'd0, 32'd0, 32'd1); tick();
    set_idle();
    repeat (3) begin tick(); chk("t2_wait", dest_o, 64'd0); end
    alu_d = 5'd2; alu_v = 32'h11; tick();
    set_idle(); tick();
    chk("t2_dest", dest_o, 64'd4); chk("t2_vj", vj_o, 64'h11);
    tick();

    // insert bypass from LS bus
    issue(5'd6, OP_ADD, 5'd0, 5'd5, 32'd1, 32'd0); ls_d = 5'd5; ls_v = 32'hAB; tick();
    set_idle(); tick();
    chk("t3_dest", dest_o, 64'd6); chk("t3_vk", vk_o, 64'hAB);
    tick();

    // full threshold and in-order drain
    for (int i = 0; i < 15; i++) begin
      issue(rob_id_t'(10 + i), OP_ADD, 5'd9, 5'd0, 32'd0, 32'(i)); tick();
      if (i == 13) chk("t4_notfull14", full, 64'd0);
    end
    set_idle();
    chk("t4_full15", full, 64'd1);
    alu_d = 5'd9; alu_v = 32'h99; tick();
    set_idle();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t4_order", dest_o, 64'(10 + i));
      chk("t4_vk", vk_o, 64'(i));
      if (i == 0) chk("t4_full_drop", full, 64'd0);
    end
    tick();
    chk("t4_idle", dest_o, 64'd0);

    // flush with bundle in flight
    for (int i = 0; i < 5; i++) begin issue(rob_id_t'(25 + i), OP_ADD, 5'd20, 5'd0, 32'd0, 32'd0); tick(); end
    issue(5'd30, OP_ADD, 5'd0, 5'd0, 32'd3, 32'd4); flush = 1'b1; tick();
    chk("t5_flush_dest", dest_o, 64'd0);
    set_idle(); alu_d = 5'd20; alu_v = 32'h20; tick();
    set_idle();
    repeat (3) begin tick(); chk("t5_none", dest_o, 64'd0); end
    chk("t5_empty", full, 64'd0);

    // async reset mid-dispatch
    issue(5'd7, OP_ADD, 5'd0, 5'd0, 32'h77, 32'd1); tick();
    set_idle(); tick();
    chk("t6_pre", dest_o, 64'd7);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_dest", dest_o, 64'd0); chk("t6_rst_vj", vj_o, 64'd0);
    model_reset();
    #2 rst = 1'b0;

    // rdy low freezes
    issue(5'd8, OP_ADD, 5'd0, 5'd0, 32'h88, 32'd2); tick();
    set_idle(); rdy = 1'b0;
    repeat (3) begin tick(); chk("t6_frozen", dest_o, 64'd0); end
    rdy = 1'b1; tick();
    chk("t6_resume", dest_o, 64'd8); chk("t6_resume_vj", vj_o, 64'h88);
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1 && model_free() >= 1)
        issue(rob_id_t'($urandom_range(1, 31)), op_t'($urandom_range(0, 63)),
              ($urandom_range(0, 1) == 1) ? 5'd0 : rob_id_t'($urandom_range(1, 7)),
              ($urandom_range(0, 1) == 1) ? 5'd0 : rob_id_t'($urandom_range(1, 7)),
              $urandom, $urandom);
      alu_d = ($urandom_range(0, 2) == 0) ? 5'd0 : rob_id_t'($urandom_range(1, 7));
      ls_d  = ($urandom_range(0, 2) == 0) ? 5'd0 : rob_id_t'($urandom_range(1, 7));
      alu_v = $urandom; ls_v = $urandom;
      tick();
    end
    set_idle();
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
